// File: rtl/membus_arbiter.sv
// membus_arbiter
//   Shares one sram-style memory bus between the instruction-fetch port (if_*)
//   and the load/store port (ls_*). The grant is registered, so m_req rises one
//   cycle after a request is seen. An in-order owner FIFO routes each m_data_ok
//   back to the port that issued it. A starvation counter lets IF win after
//   STARVE_LIMIT consecutive LS grants. A jump flush marks all outstanding
//   fetches so their responses are discarded.
//
// Ports
//   ACLK, ARESET                        clock, asynchronous active-high reset
//   if_req/if_addr/if_flush             fetch request, address, jump flush
//   if_addr_ok/if_data_ok/if_rdata      fetch address accept, response, data
//   ls_req/ls_we/ls_addr/ls_wdata/ls_wmask  load/store request and fields
//   ls_addr_ok/ls_data_ok/ls_rdata      load/store address accept, response, data
//   m_req/m_we/m_addr/m_wdata/m_wmask   downstream request towards the AXI bridge
//   m_addr_ok/m_data_ok/m_rdata         downstream accept, in-order response
//   resp_err                            sticky: response seen with nothing outstanding
module membus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = 4,
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_addr_ok,
  output logic                  if_data_ok,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  input  logic [MASK_WIDTH-1:0] ls_wmask,
  output logic                  ls_addr_ok,
  output logic                  ls_data_ok,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [MASK_WIDTH-1:0] m_wmask,
  input  logic                  m_addr_ok,
  input  logic                  m_data_ok,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  resp_err
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_LS, FULL} state_t;

  state_t           state, state_nxt;
  logic [OUTSTANDING-1:0] own_ls;   // 1 = entry belongs to LS, 0 = IF
  logic [OUTSTANDING-1:0] drop;     // fetch response to be discarded
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic [SC_W-1:0]  starve_cnt, starve_nxt;
  logic             flush_pend;     // flush seen while an IF grant waits for m_addr_ok
  logic             if_acc, ls_acc, push, pop, push_drop, starved;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // LS has priority unless IF has waited through STARVE_LIMIT LS grants.
  function automatic state_t arbitrate(input logic ireq, input logic lreq, input logic starve);
    if (ireq && (starve || !lreq)) return GNT_IF;
    else if (lreq)                 return GNT_LS;
    else                           return IDLE;
  endfunction

  assign if_acc    = (state == GNT_IF) && m_addr_ok;
  assign ls_acc    = (state == GNT_LS) && m_addr_ok;
  assign push      = if_acc || ls_acc;
  assign pop       = m_data_ok && (count != '0);
  assign push_drop = if_acc && (if_flush || flush_pend);
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  // Arbitration sees the counter value after this cycle's acceptance, so the
  // re-arbitration on the same edge already honours the starvation limit.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!if_req || if_acc)
      starve_nxt = '0;
    else if (ls_acc && (starve_cnt != SC_W'(STARVE_LIMIT)))
      starve_nxt = starve_cnt + SC_W'(1);
  end

  assign starved = (starve_nxt == SC_W'(STARVE_LIMIT));

  always_comb begin
    state_nxt  = state;
    m_req      = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_wmask    = '0;
    if_addr_ok = if_acc;
    ls_addr_ok = ls_acc;
    if_data_ok = 1'b0;
    ls_data_ok = 1'b0;
    if_rdata   = '0;
    ls_rdata   = '0;
    case (state)
      IDLE: state_nxt = arbitrate(if_req, ls_req, starved);
      GNT_IF: begin
        m_req  = 1'b1;
        m_addr = if_addr;
        if (m_addr_ok)
          state_nxt = (count_nxt == CNT_W'(OUTSTANDING)) ? FULL : arbitrate(if_req, ls_req, starved);
      end
      GNT_LS: begin
        m_req   = 1'b1;
        m_we    = ls_we;
        m_addr  = ls_addr;
        m_wdata = ls_wdata;
        m_wmask = ls_wmask;
        if (m_addr_ok)
          state_nxt = (count_nxt == CNT_W'(OUTSTANDING)) ? FULL : arbitrate(if_req, ls_req, starved);
      end
      FULL: if (pop) state_nxt = arbitrate(if_req, ls_req, starved);
      default: state_nxt = IDLE;
    endcase
    if (pop) begin
      if (own_ls[rd_ptr]) begin
        ls_data_ok = 1'b1;
        ls_rdata   = m_rdata;
      end else if (!drop[rd_ptr]) begin
        if_data_ok = 1'b1;
        if_rdata   = m_rdata;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      own_ls     <= '0;
      drop       <= '0;
      starve_cnt <= '0;
      flush_pend <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      starve_cnt <= starve_nxt;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (if_flush) begin
        for (int i = 0; i < OUTSTANDING; i++)
          if (!own_ls[i]) drop[i] <= 1'b1;
      end
      // The entry pushed this cycle overrides the flush marking of its slot.
      if (push) begin
        own_ls[wr_ptr] <= ls_acc;
        drop[wr_ptr]   <= push_drop;
      end
      if ((state == GNT_IF) && !m_addr_ok)
        flush_pend <= flush_pend || if_flush;
      else
        flush_pend <= 1'b0;
      if (m_data_ok && (count == '0))
        resp_err <= 1'b1;
    end
  end

endmodule
